// File: rtl/gpio_bank_pkg.sv
// Shared constants for the GPIO bank: register indices and bus data width.
package gpio_bank_pkg;

  localparam int unsigned GPIO_BUS_W = 32;

  localparam logic [2:0] GPIO_REG_IN       = 3'd0;
  localparam logic [2:0] GPIO_REG_OUT      = 3'd1;
  localparam logic [2:0] GPIO_REG_OE       = 3'd2;
  localparam logic [2:0] GPIO_REG_RISE_EN  = 3'd3;
  localparam logic [2:0] GPIO_REG_FALL_EN  = 3'd4;
  localparam logic [2:0] GPIO_REG_PENDING  = 3'd5;
  localparam logic [2:0] GPIO_REG_IRQ_MASK = 3'd6;
  localparam logic [2:0] GPIO_REG_RSVD     = 3'd7;

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin input conditioner: two-flop synchroniser followed by a stability filter.
module gpio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic filtered_o
);

  localparam int unsigned CntW = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 :
                                 $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            filt_q, filt_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised input disagrees with the filtered value.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filtered_o = filt_q;

endmodule

// File: rtl/gpio_bank.sv
// Parametrised GPIO bank: registered pad outputs, debounced inputs, edge interrupts
// with sticky write-1-to-clear pending bits, behind a single-cycle valid/ready bus.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int unsigned        GPIO_NO         = 4,
  parameter int unsigned        DEBOUNCE_CYCLES = 16,
  parameter logic [GPIO_NO-1:0] RESET_OE        = '0
) (
  input  logic                  io_clock,
  input  logic                  io_reset,
  input  logic [GPIO_NO-1:0]    io_pins_read,
  output logic [GPIO_NO-1:0]    io_pins_write,
  output logic [GPIO_NO-1:0]    io_pins_writeEnable,
  input  logic                  io_bus_valid,
  input  logic                  io_bus_write,
  input  logic [2:0]            io_bus_addr,
  input  logic [GPIO_BUS_W-1:0] io_bus_wdata,
  output logic [GPIO_BUS_W-1:0] io_bus_rdata,
  output logic                  io_bus_ready,
  output logic                  io_irq
);

  logic [GPIO_NO-1:0] filtered;

  for (genvar i = 0; i < GPIO_NO; i++) begin : g_pin
    gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i     (io_clock),
      .rst_ni    (io_reset),
      .pin_i     (io_pins_read[i]),
      .filtered_o(filtered[i])
    );
  end

  logic [GPIO_NO-1:0]    out_q, out_d, oe_q, oe_d;
  logic [GPIO_NO-1:0]    rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [GPIO_NO-1:0]    pending_q, pending_d, mask_q, mask_d;
  logic [GPIO_NO-1:0]    filt_dly_q;
  logic [GPIO_BUS_W-1:0] rdata_q, rdata_d;
  logic                  ready_q, irq_q, irq_d;

  logic                  wr_en;
  logic [GPIO_NO-1:0]    wd, w1c, evt, rd_sel;
  logic                  unused_wdata;

  assign wr_en        = io_bus_valid & io_bus_write;
  assign wd           = io_bus_wdata[GPIO_NO-1:0];
  assign unused_wdata = ^io_bus_wdata;
  assign evt          = (filtered & ~filt_dly_q & rise_en_q) |
                        (~filtered & filt_dly_q & fall_en_q);

  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    mask_d    = mask_q;
    w1c       = '0;
    if (wr_en) begin
      case (io_bus_addr)
        GPIO_REG_OUT:      out_d     = wd;
        GPIO_REG_OE:       oe_d      = wd;
        GPIO_REG_RISE_EN:  rise_en_d = wd;
        GPIO_REG_FALL_EN:  fall_en_d = wd;
        GPIO_REG_PENDING:  w1c       = wd;
        GPIO_REG_IRQ_MASK: mask_d    = wd;
        default: ;
      endcase
    end
    // A new event wins over a simultaneous clear.
    pending_d = (pending_q & ~w1c) | evt;

    case (io_bus_addr)
      GPIO_REG_IN:       rd_sel = filtered;
      GPIO_REG_OUT:      rd_sel = out_q;
      GPIO_REG_OE:       rd_sel = oe_q;
      GPIO_REG_RISE_EN:  rd_sel = rise_en_q;
      GPIO_REG_FALL_EN:  rd_sel = fall_en_q;
      GPIO_REG_PENDING:  rd_sel = pending_q;
      GPIO_REG_IRQ_MASK: rd_sel = mask_q;
      default:           rd_sel = '0;
    endcase
    rdata_d = io_bus_valid ? GPIO_BUS_W'(rd_sel) : '0;
    irq_d   = |(pending_q & mask_q);
  end

  always_ff @(posedge io_clock) begin
    if (!io_reset) begin
      out_q      <= '0;
      oe_q       <= RESET_OE;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      filt_dly_q <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      oe_q       <= oe_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      filt_dly_q <= filtered;
      rdata_q    <= rdata_d;
      ready_q    <= io_bus_valid;
      irq_q      <= irq_d;
    end
  end

  assign io_pins_write       = out_q;
  assign io_pins_writeEnable = oe_q;
  assign io_bus_rdata        = rdata_q;
  assign io_bus_ready        = ready_q;
  assign io_irq              = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank with 4 pins and a 16-cycle debounce.
module tb_gpio_bank;
  import gpio_bank_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  pins_in;
  logic [3:0]  pins_out;
  logic [3:0]  pins_oe;
  logic        valid;
  logic        write;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gpio_bank #(
    .GPIO_NO        (4),
    .DEBOUNCE_CYCLES(16),
    .RESET_OE       (4'h0)
  ) dut (
    .io_clock           (clk),
    .io_reset           (rst_n),
    .io_pins_read       (pins_in),
    .io_pins_write      (pins_out),
    .io_pins_writeEnable(pins_oe),
    .io_bus_valid       (valid),
    .io_bus_write       (write),
    .io_bus_addr        (addr),
    .io_bus_wdata       (wdata),
    .io_bus_rdata       (rdata),
    .io_bus_ready       (ready),
    .io_irq             (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the ready cycle.
  task automatic bus_xfer(input logic wr, input logic [2:0] a, input logic [31:0] wd,
                          output logic [31:0] rd);
    valid = 1'b1;
    write = wr;
    addr  = a;
    wdata = wd;
    @(posedge clk);
    #1;
    check_eq("bus_ready", 32'(ready), 32'd1);
    rd    = rdata;
    valid = 1'b0;
    write = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;
  int          first;
  logic [31:0] tp_exp [8];

  initial begin
    rst_n   = 1'b0;
    pins_in = 4'h0;
    valid   = 1'b1;
    write   = 1'b1;
    addr    = GPIO_REG_OUT;
    wdata   = 32'hF;

    // Reset held with a write pending: nothing may respond or change.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("rst_ready", 32'(ready), 32'd0);
      check_eq("rst_rdata", rdata, 32'd0);
      check_eq("rst_out", 32'(pins_out), 32'd0);
      check_eq("rst_oe", 32'(pins_oe), 32'd0);
      check_eq("rst_irq", 32'(irq), 32'd0);
    end
    rst_n = 1'b1;
    valid = 1'b0;
    write = 1'b0;
    bus_xfer(1'b0, GPIO_REG_OE, 32'd0, rd);
    check_eq("rst_rd_oe", rd, 32'h0);
    bus_xfer(1'b0, GPIO_REG_OUT, 32'd0, rd);
    check_eq("rst_rd_out", rd, 32'h0);

    // Outputs; upper wdata bits must be ignored.
    bus_xfer(1'b1, GPIO_REG_OUT, 32'hFFFF_FFFA, rd);
    check_eq("pins_write", 32'(pins_out), 32'hA);
    bus_xfer(1'b1, GPIO_REG_OE, 32'hF, rd);
    check_eq("pins_oe", 32'(pins_oe), 32'hF);
    bus_xfer(1'b0, GPIO_REG_OUT, 32'd0, rd);
    check_eq("rd_out", rd, 32'hA);
    bus_xfer(1'b0, GPIO_REG_OE, 32'd0, rd);
    check_eq("rd_oe", rd, 32'hF);

    // Glitch of 10 cycles must be filtered out.
    pins_in[0] = 1'b1;
    wait_cycles(10);
    pins_in[0] = 1'b0;
    wait_cycles(30);
    bus_xfer(1'b0, GPIO_REG_IN, 32'd0, rd);
    check_eq("glitch_in", rd, 32'h0);

    // Filtered flips at edge 18 after the pad edge; read accepted at edge 19 sees it first.
    pins_in[0] = 1'b1;
    valid      = 1'b1;
    write      = 1'b0;
    addr       = GPIO_REG_IN;
    first      = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (first == 0 && rdata[0]) first = n;
    end
    valid = 1'b0;
    check_eq("in_latency", first, 32'd19);

    // Falling edge with no enables must not set pending.
    pins_in[0] = 1'b0;
    wait_cycles(25);
    bus_xfer(1'b1, GPIO_REG_RISE_EN, 32'h1, rd);
    bus_xfer(1'b1, GPIO_REG_IRQ_MASK, 32'h1, rd);
    bus_xfer(1'b0, GPIO_REG_PENDING, 32'd0, rd);
    check_eq("pend_idle", rd, 32'h0);

    // Rising edge: pending at edge 19, irq at edge 20.
    pins_in[0] = 1'b1;
    wait_cycles(19);
    check_eq("irq_early", 32'(irq), 32'd0);
    wait_cycles(1);
    check_eq("irq_rise", 32'(irq), 32'd1);
    bus_xfer(1'b0, GPIO_REG_PENDING, 32'd0, rd);
    check_eq("pend_rise", rd, 32'h1);
    bus_xfer(1'b1, GPIO_REG_PENDING, 32'h1, rd);
    wait_cycles(1);
    check_eq("irq_clr", 32'(irq), 32'd0);
    pins_in[0] = 1'b0;
    wait_cycles(25);
    bus_xfer(1'b0, GPIO_REG_PENDING, 32'd0, rd);
    check_eq("pend_nofall", rd, 32'h0);
    check_eq("irq_nofall", 32'(irq), 32'd0);

    // Clear of bit 1 lands on the same edge its fall event sets it.
    bus_xfer(1'b1, GPIO_REG_FALL_EN, 32'h2, rd);
    bus_xfer(1'b1, GPIO_REG_IRQ_MASK, 32'h3, rd);
    pins_in[1] = 1'b1;
    wait_cycles(25);
    bus_xfer(1'b0, GPIO_REG_PENDING, 32'd0, rd);
    check_eq("pend_pin1_rise", rd, 32'h0);
    pins_in[1] = 1'b0;
    wait_cycles(18);
    bus_xfer(1'b1, GPIO_REG_PENDING, 32'h2, rd);
    wait_cycles(1);
    check_eq("irq_collide", 32'(irq), 32'd1);
    bus_xfer(1'b0, GPIO_REG_PENDING, 32'd0, rd);
    check_eq("pend_collide", rd, 32'h2);

    // Back-to-back reads of the whole map.
    tp_exp = '{32'h0, 32'hA, 32'hF, 32'h1, 32'h2, 32'h2, 32'h3, 32'h0};
    valid  = 1'b1;
    write  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      addr = 3'(k);
      @(posedge clk);
      #1;
      check_eq($sformatf("tp_ready%0d", k), 32'(ready), 32'd1);
      check_eq($sformatf("tp_rdata%0d", k), rdata, tp_exp[k]);
    end
    valid = 1'b0;
    wait_cycles(1);
    check_eq("tp_idle_ready", 32'(ready), 32'd0);
    check_eq("tp_idle_rdata", rdata, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
